// File: rtl/c_mux4_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : c_mux4_arbiter_pkg
// Purpose  : Constants shared by the 4-way round-robin arbiter and its
//            round-robin picker.
// Contents : N_REQ          number of requesters
//            PTR_W          width of the priority pointer / winner index
//            DEFAULT_WIDTH  default data width of requester and output ports
// Revision : 1.0  initial release
// ============================================================================
package c_mux4_arbiter_pkg;
  localparam int N_REQ         = 4;
  localparam int PTR_W         = 2;
  localparam int DEFAULT_WIDTH = 16;
endpackage
`default_nettype wire

// File: rtl/c_Mux4Way16.sv
`default_nettype none
// ============================================================================
// Module   : c_Mux4Way16
// Purpose  : Combinational 4-way data multiplexer.
// Ports    : a, b, c, d  in   WIDTH  data inputs 0..3
//            sel         in   2      selects a (0), b (1), c (2) or d (3)
//            out         out  WIDTH  selected data
// Revision : 1.0  initial release
// ============================================================================
module c_Mux4Way16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = a;
    case (sel)
      2'd0:    out = a;
      2'd1:    out = b;
      2'd2:    out = c;
      default: out = d;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/c_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module   : c_rr_pick4
// Purpose  : Combinational round-robin picker for four requesters. The
//            search starts at ptr and proceeds ptr, ptr+1, ptr+2, ptr+3
//            (mod 4); the first active request found wins.
// Ports    : req     in   4  request vector
//            ptr     in   2  priority pointer (highest-priority index)
//            any     out  1  at least one request is active
//            winner  out  2  index of the chosen requester (0 when any=0)
//            onehot  out  4  one-hot form of winner (all zero when any=0)
// Revision : 1.0  initial release
// ============================================================================
module c_rr_pick4
  import c_mux4_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic             any,
  output logic [PTR_W-1:0] winner,
  output logic [N_REQ-1:0] onehot
);

  always_comb begin : p_pick
    logic [PTR_W-1:0] idx;
    any    = 1'b0;
    winner = '0;
    onehot = '0;
    idx    = '0;
    // Walk from the lowest priority position down to ptr itself, so the
    // candidate nearest to ptr overwrites any farther one.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + PTR_W'(k);
      if (req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
    if (any) begin
      onehot = N_REQ'(1) << winner;
    end
  end

endmodule
`default_nettype wire

// File: rtl/c_mux4_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : c_mux4_arbiter
// Purpose  : Four-requester round-robin arbiter feeding a single registered
//            output word with a valid/ready handshake towards the consumer.
// Ports    : clk        in   1      clock, rising edge
//            reset_n    in   1      asynchronous active-low reset
//            req        in   4      req[i]=1: requester i has valid data
//            a, b, c, d in   WIDTH  data of requesters 0..3
//            ack        out  4      one-hot, requester captured this cycle
//            out        out  WIDTH  registered winning data
//            out_valid  out  1      out holds an unconsumed word
//            out_ready  in   1      consumer accepts out
//            out_src    out  2      requester index of the word in out
// Revision : 1.0  initial release
// ============================================================================
module c_mux4_arbiter
  import c_mux4_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [N_REQ-1:0] ack,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PTR_W-1:0] out_src
);

  logic [PTR_W-1:0] r_ptr;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic [PTR_W-1:0] r_out_src;

  logic             w_any;
  logic [PTR_W-1:0] w_winner;
  logic [N_REQ-1:0] w_onehot;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_can_load;
  logic             w_grant;

  c_rr_pick4 u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .any    (w_any),
    .winner (w_winner),
    .onehot (w_onehot)
  );

  c_Mux4Way16 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (w_winner),
    .out (w_sel_data)
  );

  // The output register accepts a new word when empty or when the current
  // word is consumed in this same cycle (back-to-back, no bubble).
  assign w_can_load = !r_out_valid || out_ready;
  assign w_grant    = w_can_load && w_any;

  // Gating with reset_n keeps ack low during reset even though the
  // picker itself is purely combinational.
  assign ack = (w_grant && reset_n) ? w_onehot : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_src   <= '0;
    end else if (w_grant) begin
      r_out       <= w_sel_data;
      r_out_src   <= w_winner;
      r_out_valid <= 1'b1;
      r_ptr       <= w_winner + PTR_W'(1);
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign out_src   = r_out_src;

endmodule
`default_nettype wire

// File: tb/tb_c_mux4_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_c_mux4_arbiter
// Purpose  : Self-checking bench for c_mux4_arbiter. Directed stimulus pushes
//            the expected word for every grant into a scoreboard queue; a
//            monitor pops and compares whenever the consumer handshake
//            (out_valid && out_ready) occurs.
// Revision : 1.0  initial release
// ============================================================================
module tb_c_mux4_arbiter;

  localparam int WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       src;
  } word_t;

  logic             clk;
  logic             reset_n;
  logic [3:0]       req;
  logic [WIDTH-1:0] a, b, c, d;
  logic [3:0]       ack;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_src;

  word_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  c_mux4_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .ack       (ack),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic word_t word_for(input logic [3:0] oh);
    word_t w;
    case (oh)
      4'b0001: w = '{data: a, src: 2'd0};
      4'b0010: w = '{data: b, src: 2'd1};
      4'b0100: w = '{data: c, src: 2'd2};
      default: w = '{data: d, src: 2'd3};
    endcase
    return w;
  endfunction

  // Called at posedge+1: drive inputs, check ack at the negedge, record the
  // expected word for a grant, then advance to the next posedge+1.
  task automatic step(input logic [3:0] r, input logic rdy, input logic [3:0] exp_ack,
                      input string name);
    req       = r;
    out_ready = rdy;
    @(negedge clk);
    check(name, 32'(ack), 32'(exp_ack));
    if (exp_ack != 4'b0000) exp_q.push_back(word_for(exp_ack));
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every consumed word against the scoreboard.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL mon_unexpected: got out=%0h src=%0d, expected no word", out, out_src);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        if (out !== e.data || out_src !== e.src) begin
          n_fail++;
          $display("FAIL mon_word: got out=%0h src=%0d, expected out=%0h src=%0d",
                   out, out_src, e.data, e.src);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; req = 4'b0000; out_ready = 1'b0;
    a = 16'h1234; b = 16'h0000; c = 16'h0000; d = 16'h0000;

    // Reset held 3 cycles; ack must stay low even with all requests active.
    repeat (3) @(posedge clk);
    #1;
    req = 4'b1111; out_ready = 1'b1;
    #1;
    check("rst_out",       32'(out),       32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_src",   32'(out_src),   32'h0);
    check("rst_ack",       32'(ack),       32'h0);
    @(negedge clk);
    reset_n = 1'b1; req = 4'b0000; out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Single request after reset.
    step(4'b0001, 1'b1, 4'b0001, "single_ack");
    check("single_out",       32'(out),       32'h1234);
    check("single_out_src",   32'(out_src),   32'h0);
    check("single_out_valid", 32'(out_valid), 32'h1);

    a = 16'hA000; b = 16'hB000; c = 16'hC000; d = 16'hD000;
    // Grant 3 alone (ptr 1 -> search 1,2,3), leaving ptr at 0.
    step(4'b1000, 1'b1, 4'b1000, "to_ptr0_ack");

    // All four requests, continuous accept: strict rotation.
    for (int i = 0; i < 8; i++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (i % 4);
      step(4'b1111, 1'b1, oh, $sformatf("rr_ack_%0d", i));
    end

    // ptr=0, only requester 1 asks: B000 loaded while D000 drains.
    step(4'b0010, 1'b1, 4'b0010, "bp_load_ack");
    for (int i = 0; i < 5; i++) begin
      step(4'b1101, 1'b0, 4'b0000, $sformatf("bp_ack_%0d", i));
      check("bp_out",       32'(out),       32'hB000);
      check("bp_out_src",   32'(out_src),   32'h1);
      check("bp_out_valid", 32'(out_valid), 32'h1);
    end
    // Release: ptr=2 so requester 2 wins in the same cycle.
    step(4'b1101, 1'b1, 4'b0100, "bp_release_ack");

    // Drain without refill.
    step(4'b0000, 1'b1, 4'b0000, "drain_ack");
    check("drain_out_valid", 32'(out_valid), 32'h0);
    check("drain_out",       32'(out),       32'hC000);
    step(4'b0000, 1'b1, 4'b0000, "idle_ready_ack");
    check("idle_out_valid", 32'(out_valid), 32'h0);

    // Pointer wrap: ptr=3, grant 3 -> ptr=0, then 1010 alternates 1,3,1.
    step(4'b1000, 1'b1, 4'b1000, "wrap_g3_ack");
    step(4'b1010, 1'b1, 4'b0010, "wrap_g1_ack");
    step(4'b1010, 1'b1, 4'b1000, "wrap_g3b_ack");
    step(4'b1010, 1'b1, 4'b0010, "wrap_g1b_ack");

    // Requester 2 withdraws before being acked; requester 0 wins (ptr=2).
    step(4'b0100, 1'b0, 4'b0000, "drop_hold_ack");
    step(4'b0001, 1'b1, 4'b0001, "drop_ack");

    // Reset mid-transfer: out holds A000, a grant to 1 is in flight.
    req = 4'b0010; out_ready = 1'b1;
    #2;
    check("mid_ack_before", 32'(ack), 32'h2);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_out",       32'(out),       32'h0);
    check("mid_out_valid", 32'(out_valid), 32'h0);
    check("mid_out_src",   32'(out_src),   32'h0);
    check("mid_ack",       32'(ack),       32'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1; req = 4'b0000;
    @(posedge clk);
    #1;
    // Search restarts at requester 0: 1001 -> 0 (ptr=1 would pick 3).
    step(4'b1001, 1'b1, 4'b0001, "post_rst_ack");
    step(4'b0000, 1'b1, 4'b0000, "post_rst_drain_ack");
    step(4'b0000, 1'b0, 4'b0000, "final_idle_ack");

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/c_mux4_arbiter.md
C_MUX4_ARBITER -- requirements
Module: c_mux4_arbiter

Interface
REQ-001 Parameter WIDTH, default 16: data width of every requester port and of the output.
REQ-002 clk  input  1  the single clock; every register updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  req[i]=1: requester i presents valid data.
REQ-005 a, b, c, d  input  WIDTH each  data of requesters 0, 1, 2, 3.
REQ-006 ack  output  4  one-hot; ack[i]=1 in the cycle requester i's data is captured.
REQ-007 out  output  WIDTH  registered winning data.
REQ-008 out_valid  output  1  out holds an unconsumed word.
REQ-009 out_ready  input  1  consumer accepts out when out_valid=1 and out_ready=1.
REQ-010 out_src  output  2  index of the requester whose data is in out.

Function
REQ-011 Request handshake: requester i holds req[i] and its data stable until ack[i]=1; transfer occurs on the edge that ends that cycle.
REQ-012 The output register can load when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
- This rule permits one word per cycle.
REQ-013 When the output register can load and req is nonzero, the block grants exactly one requester:
- selection is round-robin;
- search starts at the priority pointer ptr and proceeds ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-014 ack is combinational from req, ptr, out_valid and out_ready.
- ack=0 whenever the register cannot load or req=0.
- ack is forced to 0 while reset_n=0.
REQ-015 On a grant to requester g, at the next edge:
- out <= data of g;
- out_src <= g;
- out_valid <= 1;
- ptr <= (g+1) mod 4.
REQ-016 If out_valid=1 and out_ready=1 with no grant that cycle, out_valid <= 0 at the next edge; out and out_src hold their values.
REQ-017 If out_valid=1 and out_ready=0, out, out_src and out_valid hold, and ack=0. This is backpressure.
REQ-018 Latency from grant (ack) to out_valid is 1 cycle.
REQ-019 Drain and grant in the same cycle:
- out_valid stays 1;
- the new word replaces the old at the next edge with no bubble.
REQ-020 ptr is 2 bits and wraps from 3 to 0. With no grant, ptr holds.
REQ-021 out_ready while out_valid=0 has no effect.
REQ-022 Fairness: with all four req held at 1 and out_ready=1, grants cycle 0,1,2,3,0,... one per cycle after the first load.
REQ-023 req[i] dropped before ack: no grant to i and no state change attributable to i.

Reset
REQ-024 While reset_n=0, asynchronously:
- out=0, out_valid=0, out_src=0, ptr=0, ack=0.
REQ-025 Reset asserted mid-transfer discards the pending out word. No ack is issued for a grant whose capture edge coincides with reset.
REQ-026 The first grant after reset_n deasserts evaluates from ptr=0.

Structure
REQ-027 Data selection SHALL instantiate the existing c_Mux4Way16, driven by the winner index.
- Mapping: a/b/c/d = requester 0/1/2/3; sel = winner.
REQ-028 One sub-module: c_rr_pick4, combinational.
- Inputs: req[3:0] and ptr[1:0].
- Outputs: any, winner[1:0] and a one-hot vector.
REQ-029 Shared constants file: N_REQ=4, PTR_W=2, default WIDTH=16. No other shared typedefs.

Verification
REQ-030 Reset then single request: reset_n low 3 cycles; req=0001, a=16'h1234, out_ready=1.
- Response: ack=0001 in the first cycle.
- Next cycle: out=16'h1234, out_src=0, out_valid=1.
REQ-031 All requests, continuous accept: req=1111, a..d = 16'hA000/B000/C000/D000, out_ready=1 for 8 cycles.
- Response: out sequence A000,B000,C000,D000,A000,... one per cycle.
- ack rotates 0001,0010,0100,1000.
REQ-032 Backpressure: out_valid=1 holding 16'hB000, out_ready=0 for 5 cycles, req=1101.
- Response: out, out_src and ptr stable; ack=0000.
- On out_ready=1: the grant goes to requester 2 (ptr=2) in that same cycle.
REQ-033 Pointer wrap: last grant to 3 (ptr=0), then req=1010.
- Response: grant to 1, then to 3, then to 1.
REQ-034 Drain without refill: out_valid=1, out_ready=1, req=0000.
- Response: out_valid=0 next cycle; out keeps its last value.
REQ-035 Reset mid-transfer: reset_n low asynchronously while out_valid=1 and ack active.
- Response: outputs go to 0 immediately without a clock edge; ack=0; first post-reset grant searches from requester 0.
